// File: rtl/mem_seq_ctrl_if.sv
// Unified memory port between the MIPS sequencer (master) and the memory (slave).
interface mem_seq_ctrl_if;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    modport master (output m_req, m_we, m_addr, m_wdata, input m_rdata, m_ack);
    modport slave  (input m_req, m_we, m_addr, m_wdata, output m_rdata, m_ack);
endinterface

// File: rtl/mem_seq_ctrl.sv
// Multi-cycle fetch/decode/data/commit sequencer sharing one memory port, with a bus watchdog.
// Optional single-step HOLD state is enabled by defining MEM_SEQ_STEP_EN.
module mem_seq_ctrl #(
    parameter int TIMEOUT  = 200,
    parameter int TO_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
`ifdef MEM_SEQ_STEP_EN
    input  logic        step,
`endif
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        cpu_en,
    output logic        busy,
    output logic        bus_err,
    mem_seq_ctrl_if.master mem
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;
`ifdef MEM_SEQ_STEP_EN
    localparam logic [2:0] S_HOLD   = 3'd6;
    localparam logic [2:0] S_PRE_COMMIT = S_HOLD;
`else
    localparam logic [2:0] S_PRE_COMMIT = S_COMMIT;
`endif

    localparam logic [TO_WIDTH-1:0] TO_LIM = TO_WIDTH'(TIMEOUT);
    localparam bit                  WD_EN  = (TIMEOUT != 0);

    logic [2:0]          state, state_nx;
    logic [TO_WIDTH-1:0] wd_cnt, wd_nx, wd_inc;
    logic                wd_expire;

    // Saturating increment: a hung bus with the watchdog disabled must not wrap.
    assign wd_inc    = (wd_cnt == '1) ? wd_cnt : wd_cnt + 1'b1;
    assign wd_expire = WD_EN && (wd_inc == TO_LIM);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_nx = state;
        wd_nx    = wd_cnt;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nx = S_FETCH;
                    wd_nx    = '0;
                end
            end
            S_FETCH: begin
                if (mem.m_ack) begin
                    state_nx = S_DECODE;
                end else begin
                    wd_nx = wd_inc;
                    if (wd_expire) state_nx = S_ERR;
                end
            end
            S_DECODE: begin
                if (d_ren || d_wen) begin
                    state_nx = S_DATA;
                    wd_nx    = '0;
                end else begin
                    state_nx = S_PRE_COMMIT;
                end
            end
            S_DATA: begin
                if (mem.m_ack) begin
                    state_nx = S_PRE_COMMIT;
                end else begin
                    wd_nx = wd_inc;
                    if (wd_expire) state_nx = S_ERR;
                end
            end
`ifdef MEM_SEQ_STEP_EN
            S_HOLD: begin
                if (step) state_nx = S_COMMIT;
            end
`endif
            S_COMMIT: begin
                if (run) begin
                    state_nx = S_FETCH;
                    wd_nx    = '0;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_ERR:   state_nx = S_ERR;
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wd_cnt    <= '0;
            inst_data <= '0;
            d_rdata   <= '0;
        end else begin
            state  <= state_nx;
            wd_cnt <= wd_nx;
            if (state == S_FETCH && mem.m_ack) inst_data <= mem.m_rdata;
            // A simultaneous read and write is a write: load data is left untouched.
            if (state == S_DATA && mem.m_ack && d_ren && !d_wen) d_rdata <= mem.m_rdata;
        end
    end

    always_comb begin
        mem.m_req   = 1'b0;
        mem.m_we    = 1'b0;
        mem.m_addr  = '0;
        mem.m_wdata = '0;
        case (state)
            S_FETCH: begin
                mem.m_req  = 1'b1;
                mem.m_addr = inst_addr;
            end
            S_DATA: begin
                mem.m_req   = 1'b1;
                mem.m_we    = d_wen;
                mem.m_addr  = d_addr;
                mem.m_wdata = d_wdata;
            end
            default: ;
        endcase
    end

    assign cpu_en  = (state == S_COMMIT);
    assign busy    = (state != S_IDLE);
    assign bus_err = (state == S_ERR);

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed table-driven bench for mem_seq_ctrl with a wait-state memory model.
module tb_mem_seq_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ldword;
        int          fw;
        int          dw;
        int          cyc;
        logic [31:0] exp_rd;
        int          exp_wr;
    } vec_t;

`ifdef MEM_SEQ_STEP_EN
    localparam int HOLD_EXTRA = 1;
`else
    localparam int HOLD_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        step;
    logic [31:0] pc;
    logic        d_ren, d_wen;
    logic [31:0] d_addr, d_wdata;
    logic [31:0] inst_data, d_rdata;
    logic        cpu_en, busy, bus_err;

    logic [31:0] inst_word, load_word;
    int          fetch_wait, data_wait, cur_wait;
    int          wcnt = 0;
    int          tests = 0;
    int          fails = 0;
    vec_t        vecs[7];

    mem_seq_ctrl_if bus ();

    mem_seq_ctrl #(.TIMEOUT(5), .TO_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
`ifdef MEM_SEQ_STEP_EN
        .step      (step),
`endif
        .inst_addr (pc),
        .inst_data (inst_data),
        .d_ren     (d_ren),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .cpu_en    (cpu_en),
        .busy      (busy),
        .bus_err   (bus_err),
        .mem       (bus)
    );

    always #5 clk = ~clk;

    // Memory model: instruction word at the PC, load_word elsewhere, with programmable waits.
    always_comb begin
        cur_wait    = (bus.m_addr == pc) ? fetch_wait : data_wait;
        bus.m_ack   = bus.m_req && (wcnt >= cur_wait);
        bus.m_rdata = (bus.m_addr == pc) ? inst_word : load_word;
    end

    always @(posedge clk) begin
        if (!bus.m_req || bus.m_ack) wcnt <= 0;
        else                         wcnt <= wcnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_instr(input vec_t v, input int idx);
        int          n = 0, wr_n = 0, unstable = 0;
        logic        seen = 1'b0, have_prev = 1'b0;
        logic [31:0] prev_addr = '0, wr_a = '0, wr_d = '0, ci = '0, cd = '0;
        pc = v.pc; inst_word = v.inst; d_ren = v.ren; d_wen = v.wen;
        d_addr = v.addr; d_wdata = v.wdata; load_word = v.ldword;
        fetch_wait = v.fw; data_wait = v.dw;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            n++;
            if (have_prev && bus.m_req && bus.m_addr !== prev_addr) unstable++;
            have_prev = bus.m_req && !bus.m_ack;
            prev_addr = bus.m_addr;
            if (bus.m_req && bus.m_ack && bus.m_we) begin
                wr_n++; wr_a = bus.m_addr; wr_d = bus.m_wdata;
            end
            if (cpu_en) begin
                seen = 1'b1; ci = inst_data; cd = d_rdata;
            end
        end
        check($sformatf("v%0d_commit", idx), 32'(seen), 32'd1);
        check($sformatf("v%0d_cycles", idx), 32'(n), 32'(v.cyc + HOLD_EXTRA));
        check($sformatf("v%0d_inst_data", idx), ci, v.inst);
        check($sformatf("v%0d_d_rdata", idx), cd, v.exp_rd);
        check($sformatf("v%0d_writes", idx), 32'(wr_n), 32'(v.exp_wr));
        check($sformatf("v%0d_addr_stable", idx), 32'(unstable), 32'd0);
        if (v.exp_wr != 0) begin
            check($sformatf("v%0d_wr_addr", idx), wr_a, v.addr);
            check($sformatf("v%0d_wr_data", idx), wr_d, v.wdata);
        end
    endtask

    initial begin
        int          en_n, req_n;
        logic        found;

        vecs[0] = '{32'h100, 32'h00221820, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0,        0, 0, 3, 32'h0,        0};
        vecs[1] = '{32'h104, 32'h00221820, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0,        0, 0, 3, 32'h0,        0};
        vecs[2] = '{32'h108, 32'h8C030010, 1'b1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 6, 32'hDEADBEEF, 0};
        vecs[3] = '{32'h10C, 32'hAC040020, 1'b0, 1'b1, 32'h20, 32'h12345678, 32'h0,        0, 0, 4, 32'hDEADBEEF, 1};
        vecs[4] = '{32'h110, 32'h8C050014, 1'b1, 1'b0, 32'h14, 32'h0,        32'hCAFEF00D, 1, 1, 6, 32'hCAFEF00D, 0};
        vecs[5] = '{32'h114, 32'hAC060030, 1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 32'h11111111, 0, 0, 4, 32'hCAFEF00D, 1};
        vecs[6] = '{32'h118, 32'h00432020, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0,        3, 0, 6, 32'hCAFEF00D, 0};

        rst_n = 1'b0; run = 1'b0; step = 1'b1;
        pc = 32'h100; d_ren = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = '0;
        inst_word = '0; load_word = '0; fetch_wait = 0; data_wait = 0;
        #3;
        check("rst_m_req", 32'(bus.m_req), 32'd0);
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);

        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        check("idle_no_run_busy", 32'(busy), 32'd0);
        check("idle_no_run_req", 32'(bus.m_req), 32'd0);

        run = 1'b1;
        for (int i = 0; i < 7; i++) run_instr(vecs[i], i);

        // Watchdog: memory never acknowledges the next fetch.
        pc = 32'h11C; fetch_wait = 1000; d_ren = 1'b0; d_wen = 1'b0;
        for (int k = 0; k < 5; k++) @(negedge clk);
        check("wd_pre_bus_err", 32'(bus_err), 32'd0);
        check("wd_pre_m_req", 32'(bus.m_req), 32'd1);
        @(negedge clk);
        check("wd_bus_err", 32'(bus_err), 32'd1);
        check("wd_m_req", 32'(bus.m_req), 32'd0);
        en_n = 0; req_n = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cpu_en) en_n++;
            if (bus.m_req) req_n++;
        end
        check("err_no_cpu_en", 32'(en_n), 32'd0);
        check("err_no_m_req", 32'(req_n), 32'd0);
        check("err_sticky", 32'(bus_err), 32'd1);

        // Reset in the middle of a stalled store.
        rst_n = 1'b0; #1;
        check("rst2_bus_err", 32'(bus_err), 32'd0);
        pc = 32'h180; inst_word = 32'hAC070040; fetch_wait = 0; data_wait = 10;
        d_wen = 1'b1; d_addr = 32'h40; d_wdata = 32'h0BADF00D;
        @(negedge clk); rst_n = 1'b1;
        found = 1'b0; en_n = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (cpu_en) en_n++;
            if (bus.m_req && bus.m_we) found = 1'b1;
        end
        check("st_data_reached", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("st_rst_m_req", 32'(bus.m_req), 32'd0);
        check("st_rst_cpu_en", 32'(cpu_en), 32'd0);
        pc = 32'h200; inst_word = 32'h00221820; d_wen = 1'b0;
        step = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (cpu_en) en_n++;
        end
        check("st_no_commit", 32'(en_n), 32'd0);
        rst_n = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (bus.m_req) found = 1'b1;
        end
        check("restart_fetch", 32'(found), 32'd1);
        check("restart_addr", bus.m_addr, 32'h200);
        check("restart_we", 32'(bus.m_we), 32'd0);

`ifdef MEM_SEQ_STEP_EN
        en_n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cpu_en) en_n++;
        end
        check("hold_no_commit", 32'(en_n), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_m_req", 32'(bus.m_req), 32'd0);
        check("hold_inst_data", inst_data, 32'h00221820);
        step = 1'b1;
        en_n = 0; req_n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            step = 1'b0;
            if (cpu_en) en_n++;
            if (bus.m_req) req_n++;
        end
        check("step_one_commit", 32'(en_n), 32'd1);
        check("step_next_fetch", 32'(req_n > 0), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
